connect4_fsm: RTL and testbench
===============================

CONNECT4_FSM -- requirements
Module: connect4_fsm

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 Port: reset  input  1  synchronous active-high reset; highest priority.
REQ-004 Port: invalid_column  input  1  high when the current player's chosen column is full.
REQ-005 Port: player_turn  input  1  requested player to move (0 = player 1, 1 = player 2).
REQ-006 Port: in_game_status  input  2  board evaluation of the last move (00 = playing, 01 = mover has won, 10 = board full/tie, 11 = reserved, treated as 00).
REQ-007 Port: out_game_status  output  2  registered result (00 = in progress, 01 = player 1 won, 10 = player 2 won, 11 = tie).
REQ-008 Port: current_state  output  2  registered FSM state code.
REQ-009 Port: throw_again  output  1  registered; high means the current player must re-select a column.

Function
REQ-010 States and codes SHALL be: P1_TURN = 00, P2_TURN = 01, WIN = 10, TIE = 11; current_state SHALL always equal the state register.
REQ-011 Priority at each clock edge SHALL be: reset > terminal-state hold > in_game_status > invalid_column > player_turn.
REQ-012 In P1_TURN or P2_TURN with in_game_status = 01: next state WIN, out_game_status = 01 if current state is P1_TURN, 10 if P2_TURN.
REQ-013 In P1_TURN or P2_TURN with in_game_status = 10: next state TIE, out_game_status = 11.
REQ-014 In P1_TURN or P2_TURN with in_game_status = 00/11 and invalid_column = 1: state held, throw_again = 1 on the next cycle.
REQ-015 In P1_TURN or P2_TURN with in_game_status = 00/11 and invalid_column = 0: next state P2_TURN if player_turn = 1, else P1_TURN; throw_again = 0.
REQ-016 throw_again SHALL stay high for every consecutive cycle invalid_column is sampled high and clear one edge after it is sampled low.
REQ-017 WIN and TIE SHALL be terminal: state, out_game_status held and throw_again = 0 regardless of all inputs until reset.
REQ-018 out_game_status SHALL be 00 in P1_TURN and P2_TURN.
REQ-019 Latency: every input effect SHALL appear on outputs exactly one clock edge after sampling; no combinational input-to-output paths.
REQ-020 Simultaneous in_game_status win/tie and invalid_column SHALL resolve to the game result (throw_again = 0).

Reset
REQ-021 With reset = 1 at a rising edge: current_state = 00 (P1_TURN), out_game_status = 00, throw_again = 0, from any state including WIN/TIE.
REQ-022 Reset asserted mid-game SHALL discard the turn and result; play resumes at P1_TURN on the first edge with reset = 0.
REQ-023 Before the first reset the outputs are undefined; the bench SHALL apply reset before checking.

Verification
REQ-024 Reset, then invalid_column = 1, player_turn = 0 for 1 cycle -> current_state = 00, throw_again = 1; drop invalid_column -> throw_again = 0 next edge.
REQ-025 From P1_TURN, player_turn = 1 -> current_state = 01; player_turn = 0 -> 00; invalid_column = 1 with player_turn = 1 in 00 -> stays 00, throw_again = 1.
REQ-026 From any play state, in_game_status = 10 -> current_state = 11, out_game_status = 11; later input changes leave both unchanged.
REQ-027 In P1_TURN, in_game_status = 01 -> current_state = 10, out_game_status = 01; reset = 1 -> 00/00/0.
REQ-028 After reset, player_turn = 1 (state 01), then in_game_status = 01 -> current_state = 10, out_game_status = 10.
REQ-029 In P2_TURN, in_game_status = 01 and invalid_column = 1 together -> current_state = 10, out_game_status = 10, throw_again = 0.

Source files
------------

// File: rtl/connect4_fsm.sv
// Turn and result sequencer for a two-player Connect Four game.
// Tracks whose move it is, asks for a re-throw on a full column, and latches the final outcome.
module connect4_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       invalid_column,
  input  logic       player_turn,
  input  logic [1:0] in_game_status,
  output logic [1:0] out_game_status,
  output logic [1:0] current_state,
  output logic       throw_again
);

  typedef enum logic [1:0] {
    P1_TURN = 2'b00,
    P2_TURN = 2'b01,
    WIN     = 2'b10,
    TIE     = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EVAL_PLAYING = 2'b00,
    EVAL_WON     = 2'b01,
    EVAL_FULL    = 2'b10,
    EVAL_RSVD    = 2'b11
  } eval_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_P1_WIN = 2'b01;
  localparam logic [1:0] RES_P2_WIN = 2'b10;
  localparam logic [1:0] RES_TIE    = 2'b11;

  state_t state;
  eval_t  eval;

  assign eval          = eval_t'(in_game_status);
  assign current_state = state;

  // NOTE: every register here is updated with <= so all of them sample the
  // same pre-edge values; blocking = would let later lines see new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= P1_TURN;
      out_game_status <= RES_NONE;
      throw_again     <= 1'b0;
    end else begin
      unique case (state)
        WIN, TIE: begin
          // Terminal: result frozen until reset, inputs ignored.
          state           <= state;
          out_game_status <= out_game_status;
          throw_again     <= 1'b0;
        end
        default: begin
          unique case (eval)
            EVAL_WON: begin
              state           <= WIN;
              out_game_status <= (state == P1_TURN) ? RES_P1_WIN : RES_P2_WIN;
              throw_again     <= 1'b0;
            end
            EVAL_FULL: begin
              state           <= TIE;
              out_game_status <= RES_TIE;
              throw_again     <= 1'b0;
            end
            default: begin
              // Playing (reserved code behaves the same): full column wins over turn request.
              out_game_status <= RES_NONE;
              if (invalid_column) begin
                state       <= state;
                throw_again <= 1'b1;
              end else begin
                state       <= player_turn ? P2_TURN : P1_TURN;
                throw_again <= 1'b0;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_fsm.sv
// Directed bench for connect4_fsm: each step drives inputs across one rising edge,
// then compares state/result/throw_again against hand-computed values.
module tb_connect4_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       invalid_column;
  logic       player_turn;
  logic [1:0] in_game_status;
  logic [1:0] out_game_status;
  logic [1:0] current_state;
  logic       throw_again;

  int checks = 0;
  int errors = 0;

  connect4_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .invalid_column  (invalid_column),
    .player_turn     (player_turn),
    .in_game_status  (in_game_status),
    .out_game_status (out_game_status),
    .current_state   (current_state),
    .throw_again     (throw_again)
  );

  always #5 clk = ~clk;

  // Apply inputs, let one rising edge sample them, then settle 1 time unit.
  task automatic step(input logic r, input logic inv, input logic pt, input logic [1:0] gs);
    reset          = r;
    invalid_column = inv;
    player_turn    = pt;
    in_game_status = gs;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp_state,
                       input logic [1:0] exp_status, input logic exp_throw);
    checks++;
    assert ({current_state, out_game_status, throw_again} === {exp_state, exp_status, exp_throw})
    else begin
      errors++;
      $error("FAIL %s: observed state=%b status=%b throw=%b expected state=%b status=%b throw=%b",
             tag, current_state, out_game_status, throw_again, exp_state, exp_status, exp_throw);
    end
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 2'b00);  check("reset",             2'b00, 2'b00, 1'b0);

    // Full column in P1_TURN, then release
    step(0, 1, 0, 2'b00);  check("p1_invalid",        2'b00, 2'b00, 1'b1);
    step(0, 1, 1, 2'b00);  check("p1_invalid_hold",   2'b00, 2'b00, 1'b1);
    step(0, 0, 0, 2'b00);  check("p1_invalid_clear",  2'b00, 2'b00, 1'b0);

    // Turn changes
    step(0, 0, 1, 2'b00);  check("to_p2",             2'b01, 2'b00, 1'b0);
    step(0, 0, 0, 2'b00);  check("back_to_p1",        2'b00, 2'b00, 1'b0);
    step(0, 1, 1, 2'b00);  check("p1_invalid_pt1",    2'b00, 2'b00, 1'b1);
    step(0, 0, 1, 2'b11);  check("reserved_to_p2",    2'b01, 2'b00, 1'b0);
    step(0, 1, 0, 2'b00);  check("p2_invalid",        2'b01, 2'b00, 1'b1);
    step(0, 0, 1, 2'b00);  check("p2_stay",           2'b01, 2'b00, 1'b0);

    // Tie from P2_TURN while a re-throw is pending; terminal hold
    step(0, 1, 1, 2'b00);  check("p2_invalid_again",  2'b01, 2'b00, 1'b1);
    step(0, 1, 0, 2'b10);  check("tie",               2'b11, 2'b11, 1'b0);
    step(0, 1, 1, 2'b01);  check("tie_hold_a",        2'b11, 2'b11, 1'b0);
    step(0, 0, 0, 2'b00);  check("tie_hold_b",        2'b11, 2'b11, 1'b0);

    // Reset out of TIE, then P1 wins, then reset has priority over a win report
    step(1, 1, 1, 2'b01);  check("reset_from_tie",    2'b00, 2'b00, 1'b0);
    step(0, 0, 0, 2'b01);  check("p1_wins",           2'b10, 2'b01, 1'b0);
    step(0, 1, 1, 2'b10);  check("win_hold",          2'b10, 2'b01, 1'b0);
    step(1, 0, 0, 2'b00);  check("reset_from_win",    2'b00, 2'b00, 1'b0);

    // Mid-game reset discards turn; play resumes at P1_TURN
    step(0, 0, 1, 2'b00);  check("mid_to_p2",         2'b01, 2'b00, 1'b0);
    step(1, 0, 1, 2'b01);  check("mid_reset",         2'b00, 2'b00, 1'b0);
    step(0, 0, 0, 2'b00);  check("resume_p1",         2'b00, 2'b00, 1'b0);

    // P2 wins
    step(0, 0, 1, 2'b00);  check("p2_turn",           2'b01, 2'b00, 1'b0);
    step(0, 0, 0, 2'b01);  check("p2_wins",           2'b10, 2'b10, 1'b0);

    // P2 wins with simultaneous invalid_column
    step(1, 0, 0, 2'b00);  check("reset_again",       2'b00, 2'b00, 1'b0);
    step(0, 0, 1, 2'b00);  check("p2_turn_b",         2'b01, 2'b00, 1'b0);
    step(0, 1, 1, 2'b01);  check("p2_win_and_inv",    2'b10, 2'b10, 1'b0);

    // P1 tie with invalid_column
    step(1, 0, 0, 2'b00);  check("reset_final",       2'b00, 2'b00, 1'b0);
    step(0, 1, 0, 2'b10);  check("p1_tie_and_inv",    2'b11, 2'b11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
